mem_port_arbiter: RTL and testbench

//  Shares the single-port unified instruction/data memory between two requesters:
//  - the multicycle CPU (fetch plus load/store traffic from the datapath),
//  - the boot/debug loader, which fills or inspects memory.

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between the multicycle CPU and the boot/debug loader.
// One transfer in flight at a time: IDLE grants, ACCESS holds strobes LATENCY cycles, DONE acks.
module mem_port_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned LDR_PRIORITY = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic [DW-1:0] ldr_rdata,
    output logic          ldr_ack,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

    localparam logic [3:0] CntInit = 4'(LATENCY - 1);

    state_t        state;
    logic [3:0]    count;
    logic          last_ldr;   // 1 when the loader received the most recent grant
    logic          win_ldr;
    logic          we_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;

    logic          grant_ldr;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Round-robin tie break favours whoever did not win last; reset leaves last_ldr set.
    always_comb begin
        if (LDR_PRIORITY != 0) begin
            grant_ldr = ldr_req;
        end else begin
            grant_ldr = ldr_req & (~cpu_req | ~last_ldr);
        end
        sel_we    = grant_ldr ? ldr_we    : cpu_we;
        sel_addr  = grant_ldr ? ldr_addr  : cpu_addr;
        sel_wdata = grant_ldr ? ldr_wdata : cpu_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            count     <= 4'd0;
            last_ldr  <= 1'b1;
            win_ldr   <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cpu_req || ldr_req) begin
                        win_ldr  <= grant_ldr;
                        last_ldr <= grant_ldr;
                        we_r     <= sel_we;
                        addr_r   <= sel_addr;
                        wdata_r  <= sel_wdata;
                        count    <= CntInit;
                        mem_re   <= ~sel_we;
                        mem_we   <= sel_we;
                        state    <= StAccess;
                    end
                end
                StAccess: begin
                    if (count == 4'd0) begin
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        if (!we_r) begin
                            if (win_ldr) ldr_rdata <= mem_rdata;
                            else         cpu_rdata <= mem_rdata;
                        end
                        if (win_ldr) ldr_ack <= 1'b1;
                        else         cpu_ack <= 1'b1;
                        state <= StDone;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign busy      = (state != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: default, loader-priority and LATENCY=1 instances
// share requester inputs; each scenario resets all three and checks one of them.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;

    logic [31:0] a_crdata, a_lrdata, a_maddr, a_mwdata, a_mrdata;
    logic        a_cack, a_lack, a_mre, a_mwe, a_busy;
    logic [31:0] p_crdata, p_lrdata, p_maddr, p_mwdata, p_mrdata;
    logic        p_cack, p_lack, p_mre, p_mwe, p_busy;
    logic [31:0] f_crdata, f_lrdata, f_maddr, f_mwdata, f_mrdata;
    logic        f_cack, f_lack, f_mre, f_mwe, f_busy;

    integer checks = 0;
    integer errors = 0;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Read data is only driven while the read strobe is up
    assign a_mrdata = a_mre ? rd_model(a_maddr) : 32'h0;
    assign p_mrdata = p_mre ? rd_model(p_maddr) : 32'h0;
    assign f_mrdata = f_mre ? rd_model(f_maddr) : 32'h0;

    mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(2), .LDR_PRIORITY(0)) dut_a (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(a_crdata), .cpu_ack(a_cack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(a_lrdata), .ldr_ack(a_lack),
        .mem_re(a_mre), .mem_we(a_mwe), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
        .mem_rdata(a_mrdata), .busy(a_busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(2), .LDR_PRIORITY(1)) dut_p (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(p_crdata), .cpu_ack(p_cack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(p_lrdata), .ldr_ack(p_lack),
        .mem_re(p_mre), .mem_we(p_mwe), .mem_addr(p_maddr), .mem_wdata(p_mwdata),
        .mem_rdata(p_mrdata), .busy(p_busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(1), .LDR_PRIORITY(0)) dut_f (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(f_crdata), .cpu_ack(f_cack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(f_lrdata), .ldr_ack(f_lack),
        .mem_re(f_mre), .mem_we(f_mwe), .mem_addr(f_maddr), .mem_wdata(f_mwdata),
        .mem_rdata(f_mrdata), .busy(f_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    endtask

    // Leaves the bench 1ns after an edge with reset released; the next edge is edge 0
    task automatic do_reset();
        rst = 0;
        clear_inputs();
        tick();
        tick();
        rst = 1;
    endtask

    task automatic test_reset();
        do_reset();
        cpu_req = 1; cpu_addr = 32'h10;
        tick(); tick(); tick();
        rst = 0;
        #2;
        checks++;
        if ({a_cack, a_lack, a_mre, a_mwe, a_busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {a_cack, a_lack, a_mre, a_mwe, a_busy});
        end
        checks++;
        if (a_crdata !== 32'h0 || a_lrdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got cpu %h ldr %h expected 0", a_crdata, a_lrdata);
        end
        checks++;
        if (a_maddr !== 32'h0 || a_mwdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0", a_maddr, a_mwdata);
        end
        clear_inputs();
    endtask

    task automatic test_cpu_read();
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (a_mre !== (c <= 2) || a_cack !== (c == 3) || a_lack !== 1'b0 || a_busy !== (c <= 3)) begin
                errors++;
                $display("FAIL cpu_read_c%0d: got re %b ack %b lack %b busy %b expected %b %b 0 %b",
                         c, a_mre, a_cack, a_lack, a_busy, c <= 2, c == 3, c <= 3);
            end
            if (c <= 2) begin
                checks++;
                if (a_maddr !== 32'h10) begin
                    errors++;
                    $display("FAIL cpu_read_addr_c%0d: got %h expected 00000010", c, a_maddr);
                end
            end
            if (c >= 3) begin
                checks++;
                if (a_crdata !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL cpu_read_data_c%0d: got %h expected deadbeef", c, a_crdata);
                end
                cpu_req = 0;
            end
        end
    endtask

    task automatic test_round_robin();
        logic   who [0:7];
        integer cyc [0:7];
        integer n = 0, overlap = 0, idle = 0;
        do_reset();
        cpu_req = 1; cpu_addr = 32'h100;
        ldr_req = 1; ldr_addr = 32'h200;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (a_cack && a_lack) overlap++;
            if ((a_cack || a_lack) && n < 8) begin
                who[n] = a_lack;
                cyc[n] = c;
                n++;
            end
            if (!a_busy) idle++;
            if (c == 15) clear_inputs();
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL rr_ack_count: got %0d expected 4", n);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            checks++;
            if (who[i] !== i[0] || cyc[i] !== 3 + 4 * i) begin
                errors++;
                $display("FAIL rr_grant_%0d: got ldr=%b cycle %0d expected ldr=%b cycle %0d",
                         i, who[i], cyc[i], i[0], 3 + 4 * i);
            end
        end
        checks++;
        if (overlap !== 0 || idle !== 3) begin
            errors++;
            $display("FAIL rr_overlap_idle: got overlap %0d idle %0d expected 0 3", overlap, idle);
        end
        checks++;
        if (a_crdata !== rd_model(32'h100) || a_lrdata !== rd_model(32'h200)) begin
            errors++;
            $display("FAIL rr_rdata: got cpu %h ldr %h expected %h %h",
                     a_crdata, a_lrdata, rd_model(32'h100), rd_model(32'h200));
        end
    endtask

    task automatic test_ldr_priority();
        integer lacks = 0, cacks = 0;
        do_reset();
        cpu_req = 1; cpu_addr = 32'h300;
        ldr_req = 1; ldr_addr = 32'h400;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (p_lack) lacks++;
            if (p_cack) cacks++;
            if (c == 11) ldr_req = 0;
        end
        checks++;
        if (lacks !== 3 || cacks !== 0) begin
            errors++;
            $display("FAIL prio_acks: got ldr %0d cpu %0d expected 3 0", lacks, cacks);
        end
        for (int c = 12; c <= 15; c++) begin
            tick();
            checks++;
            if (p_cack !== (c == 15) || p_lack !== 1'b0) begin
                errors++;
                $display("FAIL prio_cpu_c%0d: got cack %b lack %b expected %b 0",
                         c, p_cack, p_lack, c == 15);
            end
        end
        checks++;
        if (p_crdata !== rd_model(32'h300)) begin
            errors++;
            $display("FAIL prio_cpu_rdata: got %h expected %h", p_crdata, rd_model(32'h300));
        end
        clear_inputs();
    endtask

    task automatic test_ldr_write();
        do_reset();
        ldr_req = 1; ldr_we = 0; ldr_addr = 32'h30;
        tick(); tick(); tick();
        checks++;
        if (a_lack !== 1'b1 || a_lrdata !== rd_model(32'h30)) begin
            errors++;
            $display("FAIL wr_pre_read: got ack %b data %h expected 1 %h",
                     a_lack, a_lrdata, rd_model(32'h30));
        end
        ldr_req = 0;
        tick();
        ldr_req = 1; ldr_we = 1; ldr_addr = 32'h20; ldr_wdata = 32'h1234_5678;
        for (int c = 5; c <= 6; c++) begin
            tick();
            checks++;
            if (a_mwe !== 1'b1 || a_mre !== 1'b0 || a_maddr !== 32'h20 ||
                a_mwdata !== 32'h1234_5678 || a_lack !== 1'b0) begin
                errors++;
                $display("FAIL wr_access_c%0d: got we %b re %b addr %h wdata %h ack %b expected 1 0 20 12345678 0",
                         c, a_mwe, a_mre, a_maddr, a_mwdata, a_lack);
            end
            ldr_wdata = 32'hFFFF_FFFF;
        end
        tick();
        checks++;
        if (a_lack !== 1'b1 || a_mwe !== 1'b0 || a_cack !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack: got lack %b we %b cack %b expected 1 0 0", a_lack, a_mwe, a_cack);
        end
        checks++;
        if (a_lrdata !== rd_model(32'h30) || a_mwdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL wr_hold: got rdata %h wdata %h expected %h 12345678",
                     a_lrdata, a_mwdata, rd_model(32'h30));
        end
        clear_inputs();
    endtask

    task automatic test_reset_abort();
        integer early = 0;
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        tick();
        checks++;
        if (a_mre !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got re %b expected 1", a_mre);
        end
        #2 rst = 0;
        #1;
        checks++;
        if (a_mre !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: got re %b busy %b expected 0 0", a_mre, a_busy);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            if (a_cack) early++;
        end
        rst = 1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if (a_mre !== 1'b1 || a_maddr !== 32'h40) begin
                    errors++;
                    $display("FAIL abort_reserve: got re %b addr %h expected 1 00000040", a_mre, a_maddr);
                end
            end
            if (c < 3 && a_cack) early++;
        end
        checks++;
        if (early !== 0 || a_cack !== 1'b1 || a_crdata !== rd_model(32'h40)) begin
            errors++;
            $display("FAIL abort_complete: got early %0d ack %b data %h expected 0 1 %h",
                     early, a_cack, a_crdata, rd_model(32'h40));
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h50;
        for (int c = 1; c <= 9; c++) begin
            tick();
            checks++;
            if (f_cack !== (c % 3 == 2) || f_busy !== (c % 3 != 0)) begin
                errors++;
                $display("FAIL b2b_c%0d: got ack %b busy %b expected %b %b",
                         c, f_cack, f_busy, c % 3 == 2, c % 3 != 0);
            end
        end
        checks++;
        if (f_crdata !== rd_model(32'h50)) begin
            errors++;
            $display("FAIL b2b_rdata: got %h expected %h", f_crdata, rd_model(32'h50));
        end
        clear_inputs();
    endtask

    initial begin
        rst = 0;
        clear_inputs();
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_ldr_priority();
        test_ldr_write();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
